radio_sample_packer: RTL and testbench

Downstream of the per-antenna radio capture stage. Takes the registered single-bit I/Q samples from all NUM_ANT antennas on clk16 and optionally decimates them. Packs consecutive samples into fixed-width words and buffers the words in a small FIFO. Presents them on a valid/ready stream to the correlator / readout path, with sticky overflow reporting and per-word sequence tags so consumers can detect drops.

---
 rtl/radio_sample_packer_pkg.sv | 13 +
 rtl/radio_sample_packer_if.sv | 12 +
 rtl/radio_sample_packer_fifo.sv | 48 ++++
 rtl/radio_sample_packer.sv | 87 ++++++++
 tb/tb_radio_sample_packer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/radio_sample_packer_pkg.sv
// radio_sample_packer_pkg: shared widths and defaults for the radio sample path
`define RSP_SAMPLE_W(n) (2*(n))
package radio_sample_packer_pkg;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_SEQ_W = 16;
  localparam int DROP_W = 16;
  function automatic int sample_w(input int num_ant);
    return `RSP_SAMPLE_W(num_ant);
  endfunction
  function automatic int word_w(input int num_ant, input int spw);
    return sample_w(num_ant) * spw;
  endfunction
endpackage

// File: rtl/radio_sample_packer_if.sv
// radio_sample_packer_if: valid/ready word stream with sequence tag
interface radio_sample_packer_if #(
  parameter int DATA_W = 32,
  parameter int SEQ_W = 16
);
  logic [DATA_W-1:0] m_data;
  logic [SEQ_W-1:0] m_seq;
  logic m_valid;
  logic m_ready;
  modport master(output m_data, m_seq, m_valid, input m_ready);
  modport slave(input m_data, m_seq, m_valid, output m_ready);
endinterface

// File: rtl/radio_sample_packer_fifo.sv
// packer_fifo: synchronous FIFO with push/pop and full/empty flags
module packer_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
  // a full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // storage and pointers; contents cleared so the output reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/radio_sample_packer.sv
// radio_sample_packer: decimates and packs I/Q samples into tagged words on a stream
module radio_sample_packer
  import radio_sample_packer_pkg::*;
#(
  parameter int NUM_ANT = 4,
  parameter int SAMPLES_PER_WORD = 4,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DECIM_W = 8,
  parameter int SEQ_W = DEF_SEQ_W
) (
  input  logic               clk16,
  input  logic               rst,
  input  logic               enable,
  input  logic [DECIM_W-1:0] decim,
  input  logic [NUM_ANT-1:0] data_i,
  input  logic [NUM_ANT-1:0] data_q,
  radio_sample_packer_if.master m,
  output logic               ovf,
  output logic [DROP_W-1:0]  drop_cnt,
  input  logic               clr_ovf
);
  localparam int SW = sample_w(NUM_ANT);
  localparam int WW = word_w(NUM_ANT, SAMPLES_PER_WORD);
  localparam int IW = $clog2(SAMPLES_PER_WORD);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  logic [0:0] state_q, state_d;
  logic [DECIM_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WW-1:0] acc_q, acc_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic pop, take, done, push, drop, full, empty;
  logic [WW+SEQ_W-1:0] fifo_dout;
  assign m.m_valid = !empty;
  assign m.m_data = fifo_dout[WW-1:0];
  assign m.m_seq = fifo_dout[WW+SEQ_W-1:WW];
  assign ovf = ovf_q;
  assign drop_cnt = drop_q;
  // capture, decimation and overflow bookkeeping; enable low flushes the partial word
  always_comb begin
    pop = m.m_valid && m.m_ready;
    take = enable && (state_q == ST_IDLE || cnt_q == '0);
    done = take && idx_q == IW'(SAMPLES_PER_WORD - 1);
    push = done && (!full || pop);
    drop = done && !push;
    state_d = enable ? ST_RUN : ST_IDLE;
    cnt_d = (!enable || cnt_q >= decim) ? '0 : cnt_q + DECIM_W'(1);
    idx_d = !enable ? '0 : take ? (done ? '0 : idx_q + IW'(1)) : idx_q;
    acc_d = enable ? acc_q : '0;
    if (take) acc_d[idx_q*SW +: SW] = {data_q, data_i};
    seq_d = seq_q + SEQ_W'(done);
    ovf_d = drop || (ovf_q && !clr_ovf);
    drop_d = drop ? (clr_ovf ? DROP_W'(1) : drop_q + DROP_W'(drop_q != '1)) : clr_ovf ? '0 : drop_q;
  end
  // packer state registers
  always_ff @(posedge clk16) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      seq_q <= '0;
      ovf_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      seq_q <= seq_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
    end
  end
  packer_fifo #(.W(WW + SEQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk16),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({seq_q, acc_d}),
    .dout(fifo_dout),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_radio_sample_packer.sv
// tb_radio_sample_packer: directed stimulus checked against a queue-based word model
module tb_radio_sample_packer;
  logic clk16 = 0, rst = 1, enable = 0, clr_ovf = 0;
  logic [7:0] decim = 0;
  logic [1:0] data_i = 0, data_q = 0;
  logic ovf;
  logic [15:0] drop_cnt;
  radio_sample_packer_if #(.DATA_W(16), .SEQ_W(16)) s_if();
  radio_sample_packer #(.NUM_ANT(2), .SAMPLES_PER_WORD(4), .FIFO_DEPTH(4), .DECIM_W(8), .SEQ_W(16)) dut (
    .clk16(clk16), .rst(rst), .enable(enable), .decim(decim), .data_i(data_i), .data_q(data_q),
    .m(s_if), .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );
  always #5 clk16 = ~clk16;
  typedef struct {logic [15:0] d; logic [15:0] s;} ent_t;
  ent_t mf[$];
  logic [3:0] parts[$];
  logic [15:0] mseq = 0, mdrop = 0;
  logic movf = 0;
  int rr = 0;
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_step();
    bit pop, done, full;
    logic [15:0] w;
    if (rst) begin
      mf.delete(); parts.delete(); mseq = 0; movf = 0; mdrop = 0; rr = 0;
      return;
    end
    pop = mf.size() > 0 && s_if.m_ready;
    full = mf.size() == 4;
    done = 0;
    w = 0;
    if (!enable) begin
      parts.delete(); rr = 0;
    end else begin
      if (rr % (int'(decim) + 1) == 0) parts.push_back({data_q, data_i});
      rr++;
      if (parts.size() == 4) begin
        done = 1;
        w = {parts[3], parts[2], parts[1], parts[0]};
        parts.delete();
      end
    end
    if (pop) void'(mf.pop_front());
    if (done && (!full || pop)) mf.push_back('{w, mseq});
    if (done && full && !pop) begin
      movf = 1;
      mdrop = clr_ovf ? 16'd1 : (mdrop == 16'hFFFF ? mdrop : mdrop + 16'd1);
    end else if (clr_ovf) begin
      movf = 0; mdrop = 0;
    end
    if (done) mseq++;
  endtask
  task automatic compare();
    chk("m_valid", s_if.m_valid, mf.size() > 0);
    if (mf.size() > 0) begin
      chk("m_data", s_if.m_data, mf[0].d);
      chk("m_seq", s_if.m_seq, mf[0].s);
    end
    chk("ovf", ovf, movf);
    chk("drop_cnt", drop_cnt, mdrop);
  endtask
  task automatic tick();
    model_step();
    @(posedge clk16);
    #1;
    compare();
  endtask
  task automatic set_s(input logic [3:0] s);
    data_i = s[1:0];
    data_q = s[3:2];
  endtask
  task automatic do_reset();
    rst = 1; enable = 0; s_if.m_ready = 0; clr_ovf = 0; decim = 0;
    tick();
    rst = 0;
  endtask
  task automatic samples(input int n);
    for (int i = 0; i < n; i++) begin
      set_s(4'(i));
      tick();
    end
  endtask
  initial begin
    int n;
    logic [15:0] last_seq, last_data;
    s_if.m_ready = 0;
    do_reset();
    chk("rst_valid", s_if.m_valid, 0);
    chk("rst_data", s_if.m_data, 0);
    chk("rst_seq", s_if.m_seq, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop_cnt, 0);
    // ordering and first-word latency
    enable = 1; s_if.m_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      set_s(4'(i));
      tick();
      if (i == 3) chk("t1_valid_early", s_if.m_valid, 0);
    end
    chk("t1_valid", s_if.m_valid, 1);
    chk("t1_data", s_if.m_data, 16'h4321);
    chk("t1_seq", s_if.m_seq, 0);
    for (int i = 5; i <= 8; i++) begin
      set_s(4'(i));
      tick();
    end
    chk("t1_data2", s_if.m_data, 16'h8765);
    chk("t1_seq2", s_if.m_seq, 1);
    // decimation by 3
    do_reset();
    decim = 2; enable = 1; s_if.m_ready = 1;
    for (int c = 0; c < 12; c++) begin
      set_s(4'(c));
      tick();
      if (c == 8) chk("t2_valid_early", s_if.m_valid, 0);
      if (c == 9) begin
        chk("t2_valid", s_if.m_valid, 1);
        chk("t2_data", s_if.m_data, 16'h9630);
      end
    end
    enable = 0; decim = 0;
    tick();
    // backpressure, overflow, drop coinciding with clear
    do_reset();
    enable = 1;
    for (int i = 0; i < 20; i++) begin
      set_s(4'(i));
      clr_ovf = (i == 19);
      tick();
    end
    clr_ovf = 0;
    chk("t3_ovf", ovf, 1);
    chk("t3_drop", drop_cnt, 1);
    enable = 0; s_if.m_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain_seq", s_if.m_seq, k);
      tick();
    end
    chk("t3_empty", s_if.m_valid, 0);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("t3_clr_ovf", ovf, 0);
    chk("t3_clr_drop", drop_cnt, 0);
    enable = 1;
    samples(4);
    chk("t3_next_seq", s_if.m_seq, 5);
    // full FIFO with pop on the completing edge
    do_reset();
    enable = 1;
    samples(19);
    set_s(4'd3); s_if.m_ready = 1;
    tick();
    s_if.m_ready = 0;
    chk("t4_ovf", ovf, 0);
    chk("t4_drop", drop_cnt, 0);
    chk("t4_head_seq", s_if.m_seq, 1);
    enable = 0; s_if.m_ready = 1;
    n = 0; last_seq = 0; last_data = 0;
    for (int c = 0; c < 10 && s_if.m_valid; c++) begin
      n++; last_seq = s_if.m_seq; last_data = s_if.m_data;
      tick();
    end
    chk("t4_count", n, 4);
    chk("t4_last_seq", last_seq, 4);
    chk("t4_last_data", last_data, 16'h3210);
    // enable drop discards the partial word
    do_reset();
    enable = 1; s_if.m_ready = 1;
    samples(4);
    set_s(4'hA); tick();
    set_s(4'hB); tick();
    enable = 0; tick();
    enable = 1;
    for (int i = 1; i <= 4; i++) begin
      set_s(4'(i));
      tick();
    end
    chk("t5_valid", s_if.m_valid, 1);
    chk("t5_data", s_if.m_data, 16'h4321);
    chk("t5_seq", s_if.m_seq, 1);
    // reset with queued words and overflow pending
    do_reset();
    enable = 1;
    samples(20);
    enable = 0; s_if.m_ready = 1;
    tick(); tick();
    s_if.m_ready = 0;
    chk("t6_pre_ovf", ovf, 1);
    chk("t6_pre_valid", s_if.m_valid, 1);
    rst = 1; tick(); rst = 0;
    chk("t6_valid", s_if.m_valid, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_data", s_if.m_data, 0);
    enable = 1; s_if.m_ready = 1;
    samples(4);
    chk("t6_new_valid", s_if.m_valid, 1);
    chk("t6_new_seq", s_if.m_seq, 0);
    enable = 0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
